// File: rtl/alu_result_uart_tx.sv
// Buffers LENGTH-bit ALU results in a small FIFO and streams each word out
// over UART 8N1, least-significant byte first.
module alu_result_uart_tx #(
    parameter int LENGTH       = 32,
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          res_valid,
    input  logic [LENGTH-1:0]             res_data,
    output logic                          res_ready,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int NBYTES = LENGTH / 8;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [LENGTH-1:0]   mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [CNT_W-1:0]    count_r;
    logic                overflow_r;
    logic [LENGTH-1:0]   shift_r;
    logic [LENGTH-1:0]   shift_s;
    logic [BAUD_W-1:0]   baud_r;
    logic [2:0]          bit_r;
    logic [BYTE_W-1:0]   byte_r;
    logic                tx_r;
    logic                tx_s;
    logic                push_s;
    logic                pop_s;
    logic                full_s;
    logic                baud_done_s;
    logic                last_byte_s;

    assign full_s      = (count_r == CNT_W'(FIFO_DEPTH));
    assign push_s      = res_valid & ~full_s;
    assign pop_s       = (state_r == S_IDLE) & (count_r != {CNT_W{1'b0}});
    assign baud_done_s = (baud_r == BAUD_W'(CLKS_PER_BIT - 1));
    assign last_byte_s = (byte_r == BYTE_W'(NBYTES - 1));

    assign res_ready  = ~full_s;
    assign fifo_count = count_r;
    assign tx         = tx_r;
    assign overflow   = overflow_r;
    assign busy       = (state_r != S_IDLE) | (count_r != {CNT_W{1'b0}});

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; bytes of one word run back to back without idle
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (pop_s) state_s = S_START;
                else       state_s = S_IDLE;
            end
            S_START: begin
                if (baud_done_s) state_s = S_DATA;
                else             state_s = S_START;
            end
            S_DATA: begin
                if (baud_done_s && (bit_r == 3'd7)) state_s = S_STOP;
                else                                state_s = S_DATA;
            end
            S_STOP: begin
                if (!baud_done_s)     state_s = S_STOP;
                else if (last_byte_s) state_s = S_IDLE;
                else                  state_s = S_START;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // FSM outputs: next shift-register contents and next tx level
    always_comb begin
        shift_s = shift_r;
        tx_s    = 1'b1;
        if (pop_s) begin
            shift_s = mem_r[rd_ptr_r];
        end else if ((state_r == S_DATA) && baud_done_s) begin
            shift_s = shift_r >> 1;
        end else begin
            shift_s = shift_r;
        end
        case (state_s)
            S_IDLE:  tx_s = 1'b1;
            S_START: tx_s = 1'b0;
            S_DATA:  tx_s = shift_s[0];
            S_STOP:  tx_s = 1'b1;
            default: tx_s = 1'b1;
        endcase
    end

    // Serializer datapath: baud, bit and byte counters plus registered tx
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r <= {LENGTH{1'b0}};
            baud_r  <= {BAUD_W{1'b0}};
            bit_r   <= 3'd0;
            byte_r  <= {BYTE_W{1'b0}};
            tx_r    <= 1'b1;
        end else begin
            shift_r <= shift_s;
            tx_r    <= tx_s;
            if ((state_r == S_IDLE) || baud_done_s) baud_r <= {BAUD_W{1'b0}};
            else                                    baud_r <= baud_r + BAUD_W'(1);
            if (state_r == S_START)                   bit_r <= 3'd0;
            else if ((state_r == S_DATA) && baud_done_s) bit_r <= bit_r + 3'd1;
            else                                      bit_r <= bit_r;
            if (state_r == S_IDLE)                                     byte_r <= {BYTE_W{1'b0}};
            else if ((state_r == S_STOP) && baud_done_s && !last_byte_s) byte_r <= byte_r + BYTE_W'(1);
            else                                                       byte_r <= byte_r;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
            if (res_valid && full_s) overflow_r <= 1'b1;
        end
    end

    // FIFO storage; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (push_s) mem_r[wr_ptr_r] <= res_data;
    end

endmodule

// File: tb/tb_alu_result_uart_tx.sv
// Self-checking bench for alu_result_uart_tx: a negedge UART decoder pops
// expected bytes from a scoreboard queue filled as words are pushed.
module tb_alu_result_uart_tx;

    localparam int LENGTH = 32;
    localparam int CPB    = 4;
    localparam int DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        res_valid;
    logic [31:0] res_data;
    logic        res_ready;
    logic        tx;
    logic        busy;
    logic        overflow;
    logic [2:0]  fifo_count;

    int vectors     = 0;
    int miscompares = 0;
    logic [7:0] exp_q[$];

    int         mon_phase = 0;
    int         mon_tick  = 0;
    logic [7:0] mon_byte  = 8'h00;

    alu_result_uart_tx #(
        .LENGTH(LENGTH), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .res_valid(res_valid), .res_data(res_data),
        .res_ready(res_ready), .tx(tx), .busy(busy), .overflow(overflow),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic expect_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
    endtask

    // UART decoder: sample each bit in its second clock, compare at stop bit
    always @(negedge clk) begin : uart_monitor
        int t;
        logic [7:0] e;
        if (!rst_n) begin
            mon_phase <= 0;
            mon_tick  <= 0;
        end else if (mon_phase == 0) begin
            if (tx === 1'b0) begin
                mon_phase <= 1;
                mon_tick  <= 0;
            end
        end else begin
            t = mon_tick + 1;
            mon_tick <= t;
            if (t == 1) begin
                vectors++;
                if (tx !== 1'b0) begin
                    miscompares++;
                    $display("FAIL start_bit: tx=%b expected 0 at %0t", tx, $time);
                end
            end else if (t <= 33 && ((t - 1) % CPB) == 0) begin
                mon_byte[(t - 1) / CPB - 1] <= tx;
            end else if (t == 37) begin
                vectors++;
                if (tx !== 1'b1) begin
                    miscompares++;
                    $display("FAIL stop_bit: tx=%b expected 1 at %0t", tx, $time);
                end
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL byte: got %h, expected none at %0t", mon_byte, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (mon_byte !== e) begin
                        miscompares++;
                        $display("FAIL byte: got %h expected %h at %0t", mon_byte, e, $time);
                    end
                end
                mon_phase <= 0;
            end
        end
    end

    task automatic test_reset();
        int bad;
        rst_n = 1'b0; res_valid = 1'b0; res_data = 32'h0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({tx, res_ready, busy, overflow, fifo_count} !== {1'b1, 1'b1, 1'b0, 1'b0, 3'd0}) begin
            miscompares++;
            $display("FAIL reset_state: tx=%b rdy=%b busy=%b ovf=%b cnt=%0d expected 1 1 0 0 0",
                     tx, res_ready, busy, overflow, fifo_count);
        end
        rst_n = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL idle_after_reset: %0d cycles not idle, expected 0", bad);
        end
    endtask

    task automatic test_single_word();
        int cycles;
        @(negedge clk);
        res_valid = 1'b1; res_data = 32'h12345678;
        expect_word(res_data);
        @(negedge clk);
        res_valid = 1'b0;
        vectors++;
        if (fifo_count !== 3'd1 || tx !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_push: cnt=%0d tx=%b busy=%b expected 1 1 1", fifo_count, tx, busy);
        end
        @(negedge clk);
        vectors++;
        if (tx !== 1'b0 || fifo_count !== 3'd0) begin
            miscompares++;
            $display("FAIL single_latency: tx=%b cnt=%0d expected 0 0", tx, fifo_count);
        end
        cycles = 0;
        while (busy === 1'b1 && cycles < 400) begin
            @(negedge clk);
            cycles++;
        end
        vectors++;
        if (cycles != 160) begin
            miscompares++;
            $display("FAIL single_frame_len: %0d clks expected 160", cycles);
        end
        vectors++;
        if (exp_q.size() != 0 || tx !== 1'b1) begin
            miscompares++;
            $display("FAIL single_drain: %0d bytes left tx=%b expected 0 left tx=1", exp_q.size(), tx);
        end
    endtask

    task automatic test_back_to_back();
        int hi_run, last_run, k;
        @(negedge clk);
        res_valid = 1'b1; res_data = 32'hA5A5A5A5;
        expect_word(res_data);
        @(negedge clk);
        vectors++;
        if (fifo_count !== 3'd1) begin
            miscompares++;
            $display("FAIL b2b_count_first: cnt=%0d expected 1", fifo_count);
        end
        res_data = 32'h0000FFFF;
        expect_word(res_data);
        @(negedge clk);
        res_valid = 1'b0;
        vectors++;
        if (fifo_count !== 3'd1 || tx !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_count_overlap: cnt=%0d tx=%b expected 1 0", fifo_count, tx);
        end
        hi_run = 0; last_run = 0; k = 0;
        while (fifo_count !== 3'd0 && k < 400) begin
            @(negedge clk);
            k++;
            if (tx === 1'b1) hi_run++;
            else begin
                if (hi_run > 0) last_run = hi_run;
                hi_run = 0;
            end
        end
        vectors++;
        if (k != 161 || last_run != 2 * CPB + 1) begin
            miscompares++;
            $display("FAIL b2b_idle_gap: pop after %0d clks high run %0d expected 161 and %0d",
                     k, last_run, 2 * CPB + 1);
        end
        k = 0;
        while (busy === 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        vectors++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_drain: busy=%b left=%0d expected 0 0", busy, exp_q.size());
        end
    endtask

    task automatic test_overflow();
        logic exp_rdy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int k;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            vectors++;
            if (res_ready !== exp_rdy[i]) begin
                miscompares++;
                $display("FAIL ovf_ready_%0d: rdy=%b expected %b", i + 1, res_ready, exp_rdy[i]);
            end
            res_valid = 1'b1;
            res_data  = 32'(i + 1);
            if (exp_rdy[i]) expect_word(res_data);
        end
        @(negedge clk);
        res_valid = 1'b0;
        vectors++;
        if (overflow !== 1'b1 || fifo_count !== 3'd4 || res_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_full: ovf=%b cnt=%0d rdy=%b expected 1 4 0", overflow, fifo_count, res_ready);
        end
        k = 0;
        while (busy === 1'b1 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        vectors++;
        if (busy !== 1'b0 || overflow !== 1'b1 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL ovf_drain: busy=%b ovf=%b left=%0d expected 0 1 0", busy, overflow, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        int k;
        @(negedge clk);
        res_valid = 1'b1; res_data = 32'h11223344;
        expect_word(res_data);
        @(negedge clk);
        res_valid = 1'b0;
        repeat (58) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (tx !== 1'b1 || fifo_count !== 3'd0 || busy !== 1'b0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL midframe_reset: tx=%b cnt=%0d busy=%b ovf=%b expected 1 0 0 0",
                     tx, fifo_count, busy, overflow);
        end
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midframe_no_resume: tx=%b busy=%b expected 1 0", tx, busy);
        end
        res_valid = 1'b1; res_data = 32'hDEADBEEF;
        expect_word(res_data);
        @(negedge clk);
        res_valid = 1'b0;
        k = 0;
        while (busy === 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        vectors++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL midframe_retx: busy=%b left=%0d expected 0 0", busy, exp_q.size());
        end
    endtask

    task automatic test_extremes();
        int k;
        @(negedge clk);
        res_valid = 1'b1; res_data = 32'h00000000;
        expect_word(res_data);
        @(negedge clk);
        res_data = 32'hFFFFFFFF;
        expect_word(res_data);
        @(negedge clk);
        res_valid = 1'b0;
        k = 0;
        while (busy === 1'b1 && k < 800) begin
            @(negedge clk);
            k++;
        end
        vectors++;
        if (busy !== 1'b0 || exp_q.size() != 0 || tx !== 1'b1) begin
            miscompares++;
            $display("FAIL extremes_drain: busy=%b left=%0d tx=%b expected 0 0 1", busy, exp_q.size(), tx);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
        test_extremes();
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
